// File: rtl/cpu_run_dump_ctrl.sv
// Run/dump sequencer: runs the CPU for a programmed cycle count, then streams r0..DUMP_REGS-1
// out of the register-file debug port. Optional abort input when RUN_ABORT_EN is defined.
module cpu_run_dump_ctrl #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int DUMP_REGS = 12,
   parameter int CNT_W     = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  run_cycles_i,
`ifdef RUN_ABORT_EN
   input  logic              abort_i,
`endif
   output logic              cpu_en_o,
   output logic              dbg_rd_en_o,
   output logic [ADDR_W-1:0] dbg_rd_addr_o,
   input  logic [DATA_W-1:0] dbg_rd_data_i,
   output logic              dump_valid_o,
   input  logic              dump_ready_i,
   output logic [ADDR_W-1:0] dump_addr_o,
   output logic [DATA_W-1:0] dump_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [2:0]        dbg_state_o
);

   // Dump channel: a beat transfers on a rising edge where dump_valid_o and dump_ready_i are
   // both 1. Once raised, valid/addr/data stay put until that edge; ready may lead valid and
   // is ignored whenever valid is low.

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_RD   = 3'd2,
      S_CAP  = 3'd3,
      S_OUT  = 3'd4,
      S_FIN  = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_REGS - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] idx;
   logic              abort_req;
   logic              abortable;

`ifdef RUN_ABORT_EN
   assign abort_req = abort_i;
`else
   assign abort_req = 1'b0;
`endif

   assign abortable   = (state == S_RUN) || (state == S_RD) ||
                        (state == S_CAP) || (state == S_OUT);
   assign dbg_state_o = state;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state         <= S_IDLE;
         cnt           <= '0;
         idx           <= '0;
         cpu_en_o      <= 1'b0;
         dbg_rd_en_o   <= 1'b0;
         dbg_rd_addr_o <= '0;
         dump_valid_o  <= 1'b0;
         dump_addr_o   <= '0;
         dump_data_o   <= '0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
      end else begin
         // Strobe, address and done are single-cycle unless a state re-asserts them.
         dbg_rd_en_o   <= 1'b0;
         dbg_rd_addr_o <= '0;
         done_o        <= 1'b0;

         if (abort_req && abortable) begin
            state        <= S_FIN;
            cpu_en_o     <= 1'b0;
            dump_valid_o <= 1'b0;
            done_o       <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start_i) begin
                     cnt    <= run_cycles_i;
                     idx    <= '0;
                     busy_o <= 1'b1;
                     if (run_cycles_i != '0) begin
                        state    <= S_RUN;
                        cpu_en_o <= 1'b1;
                     end else begin
                        state       <= S_RD;
                        dbg_rd_en_o <= 1'b1;
                     end
                  end
               end

               S_RUN: begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_ONE) begin
                     state         <= S_RD;
                     cpu_en_o      <= 1'b0;
                     dbg_rd_en_o   <= 1'b1;
                     dbg_rd_addr_o <= idx;
                  end
               end

               // Register file answers one cycle after the strobe; CAP samples it.
               S_RD: begin
                  state <= S_CAP;
               end

               S_CAP: begin
                  dump_data_o  <= dbg_rd_data_i;
                  dump_addr_o  <= idx;
                  dump_valid_o <= 1'b1;
                  state        <= S_OUT;
               end

               S_OUT: begin
                  if (dump_ready_i) begin
                     dump_valid_o <= 1'b0;
                     if (idx == LAST_IDX) begin
                        state  <= S_FIN;
                        done_o <= 1'b1;
                     end else begin
                        idx           <= idx + 1'b1;
                        state         <= S_RD;
                        dbg_rd_en_o   <= 1'b1;
                        dbg_rd_addr_o <= idx + 1'b1;
                     end
                  end
               end

               S_FIN: begin
                  busy_o <= 1'b0;
                  state  <= S_IDLE;
               end

               default: begin
                  state        <= S_IDLE;
                  cpu_en_o     <= 1'b0;
                  dump_valid_o <= 1'b0;
                  busy_o       <= 1'b0;
               end
            endcase
         end
      end
   end

`ifndef SYNTHESIS
   a_cpu_en_only_run: assert property (@(posedge clk_i) disable iff (!rst_i)
      cpu_en_o |-> (state == S_RUN));
   a_done_one_cycle: assert property (@(posedge clk_i) disable iff (!rst_i)
      done_o |=> !done_o);
   a_valid_only_out: assert property (@(posedge clk_i) disable iff (!rst_i)
      dump_valid_o |-> (state == S_OUT));
   a_hold_beat: assert property (@(posedge clk_i) disable iff (!rst_i)
      (dump_valid_o && !dump_ready_i && !abort_req) |=>
      (dump_valid_o && $stable(dump_data_o) && $stable(dump_addr_o)));
`endif

endmodule

// File: tb/tb_cpu_run_dump_ctrl.sv
// Bench for cpu_run_dump_ctrl: register-file model rK = K*3, expected-beat queue,
// negedge monitor that checks every accepted beat against the queue.
module tb_cpu_run_dump_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 16;
   localparam int NREGS = 12;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic [CW-1:0] run_cycles_i;
   logic          cpu_en_o;
   logic          dbg_rd_en_o;
   logic [AW-1:0] dbg_rd_addr_o;
   logic [DW-1:0] dbg_rd_data_i = '0;
   logic          dump_valid_o;
   logic          dump_ready_i = 1'b1;
   logic [AW-1:0] dump_addr_o;
   logic [DW-1:0] dump_data_o;
   logic          busy_o;
   logic          done_o;
   logic [2:0]    dbg_state_o;
`ifdef RUN_ABORT_EN
   logic          abort_i = 1'b0;
`endif

   cpu_run_dump_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DUMP_REGS(NREGS), .CNT_W(CW)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .run_cycles_i  (run_cycles_i),
`ifdef RUN_ABORT_EN
      .abort_i       (abort_i),
`endif
      .cpu_en_o      (cpu_en_o),
      .dbg_rd_en_o   (dbg_rd_en_o),
      .dbg_rd_addr_o (dbg_rd_addr_o),
      .dbg_rd_data_i (dbg_rd_data_i),
      .dump_valid_o  (dump_valid_o),
      .dump_ready_i  (dump_ready_i),
      .dump_addr_o   (dump_addr_o),
      .dump_data_o   (dump_data_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .dbg_state_o   (dbg_state_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // ---------------- register-file model (synchronous debug read) ----------------
   logic [DW-1:0] rf [0:31];
   initial for (int k = 0; k < 32; k++) rf[k] = DW'(k * 3);
   always @(posedge clk) if (dbg_rd_en_o) dbg_rd_data_i <= rf[dbg_rd_addr_o];

   // ---------------- scoreboard state ----------------
   logic [AW+DW-1:0] exp_q[$];
   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- ready driver: optional backpressure on beat r3 ----------------
   int stall_len = 0;
   int stall_cnt = 0;
   always @(posedge clk) begin
      #1;
      if (dump_valid_o && dump_addr_o == AW'(3) && stall_cnt < stall_len) begin
         dump_ready_i = 1'b0;
         stall_cnt++;
      end else begin
         dump_ready_i = 1'b1;
         if (!dump_valid_o) stall_cnt = 0;
      end
   end

   // ---------------- monitor ----------------
   int cpu_en_tot = 0;
   int done_tot = 0;
   int done_edge_last = 0;
   int hs_tot = 0;
   int stall_tot = 0;
   int hs_log [0:255];
   logic prev_stall = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_data = '0;

   always @(negedge clk) begin
      if (rst_i) begin
         if (cpu_en_o) cpu_en_tot++;
         if (done_o) begin
            done_tot++;
            done_edge_last = edge_cnt;
         end
         if (dump_valid_o && prev_stall) begin
            check("hold_addr", dump_addr_o, prev_addr);
            check("hold_data", dump_data_o, prev_data);
         end
         if (dump_valid_o && !dump_ready_i) begin
            stall_tot++;
            check("hold_no_rd_en", dbg_rd_en_o, 0);
         end
         if (dump_valid_o && dump_ready_i) begin
            hs_log[hs_tot % 256] = edge_cnt + 1;
            hs_tot++;
            if (exp_q.size() == 0) begin
               check("beat_unexpected", {dump_addr_o, dump_data_o}, '1);
            end else begin
               logic [AW+DW-1:0] e;
               e = exp_q.pop_front();
               check("beat_addr", dump_addr_o, e[AW+DW-1:DW]);
               check("beat_data", dump_data_o, e[DW-1:0]);
            end
         end
         prev_stall = dump_valid_o && !dump_ready_i;
         prev_addr  = dump_addr_o;
         prev_data  = dump_data_o;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic run_seq(input string tag, input int n, input bit pulse_start);
      int s_edge, cpu0, done0, hs0, stall0, t;
      cpu0 = cpu_en_tot; done0 = done_tot; hs0 = hs_tot; stall0 = stall_tot;
      for (int k = 0; k < NREGS; k++) exp_q.push_back({AW'(k), DW'(k * 3)});
      start_i = 1'b1;
      run_cycles_i = CW'(n);
      s_edge = edge_cnt + 1;
      @(negedge clk);
      start_i = 1'b0;
      if (n == 0) begin
         check({tag, "_rd_en_first"}, dbg_rd_en_o, 1);
         check({tag, "_rd_addr_first"}, dbg_rd_addr_o, 0);
      end
      if (pulse_start) begin
         repeat (2) @(negedge clk);
         start_i = 1'b1;
         @(negedge clk);
         start_i = 1'b0;
         t = 0;
         while (!dump_valid_o && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t >= 50) check({tag, "_valid_timeout"}, 0, 1);
         start_i = 1'b1;
         @(negedge clk);
         start_i = 1'b0;
      end
      t = 0;
      while (done_tot == done0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) check({tag, "_done_timeout"}, 0, 1);
      repeat (5) @(negedge clk);
      check({tag, "_cpu_en_cycles"}, cpu_en_tot - cpu0, n);
      check({tag, "_beats"}, hs_tot - hs0, NREGS);
      check({tag, "_done_pulses"}, done_tot - done0, 1);
      check({tag, "_first_beat_edge"}, hs_log[hs0 % 256] - s_edge, n + 3);
      check({tag, "_done_after_last"}, done_edge_last, hs_log[(hs_tot - 1) % 256]);
      check({tag, "_busy_after"}, busy_o, 0);
      check({tag, "_state_after"}, dbg_state_o, 0);
      check({tag, "_stall_cycles"}, stall_tot - stall0, stall_len);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

`ifdef RUN_ABORT_EN
   task automatic abort_seq();
      int s_edge, cpu0, done0, hs0;
      cpu0 = cpu_en_tot; done0 = done_tot; hs0 = hs_tot;
      start_i = 1'b1;
      run_cycles_i = CW'(10);
      s_edge = edge_cnt + 1;
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      check("T6_done_now", done_o, 1);
      repeat (5) @(negedge clk);
      check("T6_cpu_en_cycles", cpu_en_tot - cpu0, 2);
      check("T6_beats", hs_tot - hs0, 0);
      check("T6_done_pulses", done_tot - done0, 1);
      check("T6_done_edge", done_edge_last - s_edge, 2);
      check("T6_busy_after", busy_o, 0);
   endtask
`endif

   // ---------------- main sequence ----------------
   initial begin
      rst_i = 1'b0;
      start_i = 1'b0;
      run_cycles_i = '0;
      #1;
      check("rst_cpu_en", cpu_en_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_valid", dump_valid_o, 0);
      check("rst_done", done_o, 0);
      check("rst_rd_en", dbg_rd_en_o, 0);
      check("rst_state", dbg_state_o, 0);
      repeat (2) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);

      run_seq("T2", 5, 1'b0);
      run_seq("T3", 0, 1'b0);
      stall_len = 4;
      run_seq("T4", 5, 1'b0);
      stall_len = 0;
      run_seq("T5", 5, 1'b1);
      run_seq("T2b", 2, 1'b0);
`ifdef RUN_ABORT_EN
      abort_seq();
`endif

      // Asynchronous reset in the middle of a long run
      start_i = 1'b1;
      run_cycles_i = CW'(20);
      @(negedge clk);
      start_i = 1'b0;
      repeat (2) @(negedge clk);
      check("T1_cpu_en_before", cpu_en_o, 1);
      check("T1_busy_before", busy_o, 1);
      #2;
      rst_i = 1'b0;
      #1;
      check("T1_cpu_en_async", cpu_en_o, 0);
      check("T1_busy_async", busy_o, 0);
      check("T1_valid_async", dump_valid_o, 0);
      check("T1_state_async", dbg_state_o, 0);
      @(negedge clk);
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      check("T1_idle_after", busy_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
